// File: rtl/concat8_unpacker.sv
// Serial receive side of the packed field format {A[3:0], B[1:0], ~C, D}: deserializes
// MSB-first frames and presents the fields on a one-deep valid/ready register.
// Optional build macro UNPACK_PARITY_EN: 9-bit frames, with a trailing even-parity bit.
module concat8_unpacker #(
  parameter int unsigned ERR_CNT_W  = 8,
  parameter bit          C_INVERTED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sin_valid,
  output logic                 sin_ready,
  input  logic                 sin_data,
  input  logic                 sin_sof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           A,
  output logic [1:0]           B,
  output logic                 C,
  output logic                 D,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

`ifdef UNPACK_PARITY_EN
  localparam int unsigned FRAME_W = 9;
`else
  localparam int unsigned FRAME_W = 8;
`endif
  localparam logic [3:0] LAST_IDX = 4'(FRAME_W - 1);

  typedef enum logic [1:0] {HUNT, SHIFT, FULL} state_e;

  state_e                 state_q;
  logic [3:0]             bit_cnt_q;
  logic [FRAME_W-1:0]     shreg_q;
  logic                   out_valid_q;
  logic [3:0]             a_q;
  logic [1:0]             b_q;
  logic                   c_q;
  logic                   d_q;
  logic                   frame_err_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;

  logic                   can_load;
  logic                   xfer;
  logic                   last_bit;
  logic                   frame_ok;
  logic                   load_en;
  logic                   err_evt;
  logic [FRAME_W-1:0]     shifted;
  logic [7:0]             load_data;

  always_comb begin
    can_load  = !out_valid_q || out_ready;
    sin_ready = rst_n && ((state_q != FULL) || can_load);
    xfer      = sin_valid && sin_ready;
    shifted   = {shreg_q[FRAME_W-2:0], sin_data};
    last_bit  = (state_q == SHIFT) && xfer && !sin_sof && (bit_cnt_q == LAST_IDX);
`ifdef UNPACK_PARITY_EN
    frame_ok  = ~^shifted;
`else
    frame_ok  = 1'b1;
`endif
    // A completed frame goes straight to the output when it is free; FULL only
    // holds a frame that arrived while the output register was still occupied.
    load_en   = (last_bit && frame_ok && can_load) || ((state_q == FULL) && can_load);
    load_data = (state_q == FULL) ? shreg_q[FRAME_W-1 -: 8] : shifted[FRAME_W-1 -: 8];
    err_evt   = ((state_q == SHIFT) && xfer && sin_sof) || (last_bit && !frame_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      d_q         <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      frame_err_q <= err_evt;
      if (err_evt && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end

      if (load_en) begin
        out_valid_q <= 1'b1;
        a_q         <= load_data[7:4];
        b_q         <= load_data[3:2];
        c_q         <= load_data[1] ^ C_INVERTED;
        d_q         <= load_data[0];
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        HUNT: begin
          if (xfer && sin_sof) begin
            shreg_q   <= FRAME_W'(sin_data);
            bit_cnt_q <= 4'd1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (sin_sof) begin
              shreg_q   <= FRAME_W'(sin_data);
              bit_cnt_q <= 4'd1;
            end else if (last_bit) begin
              shreg_q   <= shifted;
              bit_cnt_q <= '0;
              state_q   <= (frame_ok && !can_load) ? FULL : HUNT;
            end else begin
              shreg_q   <= shifted;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        FULL: begin
          if (can_load) begin
            if (xfer && sin_sof) begin
              shreg_q   <= FRAME_W'(sin_data);
              bit_cnt_q <= 4'd1;
              state_q   <= SHIFT;
            end else begin
              state_q   <= HUNT;
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign C         = c_q;
  assign D         = d_q;
  assign frame_err = frame_err_q;
  assign err_count = err_cnt_q;

endmodule
